// File: rtl/key_schedule.sv
// AES-128 key schedule: streams round keys 0..10 through a ready/valid handshake,
// one key per cycle when the consumer keeps ready high.

// Round-constant lookup for AES-128; r is the round being generated (1..10).
module key_schedule_rcon (
  input  logic [3:0]  r,
  output logic [31:0] rcon_c
);

  // Constant table, byte in the top lane, zero elsewhere
  always_comb begin
    rcon_c = '0;
    case (r)
      4'd1:    rcon_c = 32'h0100_0000;
      4'd2:    rcon_c = 32'h0200_0000;
      4'd3:    rcon_c = 32'h0400_0000;
      4'd4:    rcon_c = 32'h0800_0000;
      4'd5:    rcon_c = 32'h1000_0000;
      4'd6:    rcon_c = 32'h2000_0000;
      4'd7:    rcon_c = 32'h4000_0000;
      4'd8:    rcon_c = 32'h8000_0000;
      4'd9:    rcon_c = 32'h1b00_0000;
      4'd10:   rcon_c = 32'h3600_0000;
      default: rcon_c = '0;
    endcase
  end

endmodule

module key_schedule (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 4;
  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(10);

  // Forward S-box; first listed byte lands at index 255, so look up with ~b
  localparam logic [255:0][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [KEY_W-1:0]    key_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic                valid_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic                transfer;
  logic [IDX_W-1:0]    rcon_round;
  logic [WORD_W-1:0]   rcon_word;
  logic [WORD_W-1:0]   w0, w1, w2, w3, t, n0, n1, n2, n3;

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    sub_word = {SBOX[~w[31:24]], SBOX[~w[23:16]], SBOX[~w[15:8]], SBOX[~w[7:0]]};
  endfunction

  assign transfer   = key_valid & ready;
  assign rcon_round = round_idx + IDX_W'(1);

  key_schedule_rcon u_rcon (
    .r      (rcon_round),
    .rcon_c (rcon_word)
  );

  // One AES-128 expansion step from the current round key
  always_comb begin
    {w0, w1, w2, w3} = round_key;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ rcon_word;
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: accept start in IDLE, leave RUN on the round-10 handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (transfer && round_idx == LAST_ROUND) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values; everything holds unless a load or transfer happens
  always_comb begin
    key_nxt   = round_key;
    idx_nxt   = round_idx;
    valid_nxt = key_valid;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          key_nxt   = key_in;
          idx_nxt   = '0;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (transfer) begin
          if (round_idx == LAST_ROUND) begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            key_nxt = {n0, n1, n2, n3};
            idx_nxt = rcon_round;
          end
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      round_key <= key_nxt;
      round_idx <= idx_nxt;
      key_valid <= valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule using FIPS-197 and all-zero key vectors.
module tb_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] FIPS_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  always #5 clk = ~clk;

  key_schedule dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_in    (key_in),
    .ready     (ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_round(input string tag, input int r, input logic [127:0] key);
    chk($sformatf("%s_r%0d_key", tag, r), round_key, key);
    chk($sformatf("%s_r%0d_idx", tag, r), 128'(round_idx), 128'(r));
    chk($sformatf("%s_r%0d_valid", tag, r), 128'(key_valid), 128'(1));
    chk($sformatf("%s_r%0d_busy", tag, r), 128'(busy), 128'(1));
    chk($sformatf("%s_r%0d_done", tag, r), 128'(done), 128'(0));
  endtask

  task automatic expect_done(input string tag, input logic [127:0] key);
    chk({tag, "_done_key"}, round_key, key);
    chk({tag, "_done_idx"}, 128'(round_idx), 128'(10));
    chk({tag, "_done_valid"}, 128'(key_valid), 128'(0));
    chk({tag, "_done_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done_pulse"}, 128'(done), 128'(1));
  endtask

  task automatic expect_zero(input string tag);
    chk({tag, "_key"}, round_key, 128'(0));
    chk({tag, "_idx"}, 128'(round_idx), 128'(0));
    chk({tag, "_valid"}, 128'(key_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
  endtask

  initial begin
    int idx;
    int cycles;
    bit rdy;

    // Reset and idle hold
    reset = 1'b1; start = 1'b0; ready = 1'b1; key_in = '0;
    step(); step();
    expect_zero("reset");
    reset = 1'b0;
    step();
    expect_zero("idle");

    // FIPS-197 key, ready held high: 11 keys in 11 consecutive cycles
    key_in = FIPS_KEY; start = 1'b1;
    step();
    start = 1'b0; key_in = '1;
    expect_round("fips", 0, FIPS_KEY);
    for (int r = 1; r <= 10; r++) begin
      step();
      expect_round("fips", r, FIPS_RK[r]);
    end
    step();
    expect_done("fips", FIPS_RK[10]);
    step();
    chk("fips_done_clears", 128'(done), 128'(0));
    chk("fips_hold_key", round_key, FIPS_RK[10]);
    chk("fips_hold_idx", 128'(round_idx), 128'(10));

    // All-zero key
    key_in = '0; start = 1'b1;
    step();
    start = 1'b0;
    expect_round("zero", 0, 128'(0));
    for (int r = 1; r <= 10; r++) begin
      step();
      chk($sformatf("zero_r%0d_idx", r), 128'(round_idx), 128'(r));
      if (r == 1)  chk("zero_r1_key", round_key, ZERO_R1);
      if (r == 10) chk("zero_r10_key", round_key, ZERO_R10);
    end
    step();
    expect_done("zero", ZERO_R10);

    // FIPS key with pseudo-random back-pressure
    key_in = FIPS_KEY; start = 1'b1;
    step();
    start = 1'b0;
    expect_round("stall", 0, FIPS_KEY);
    idx = 0; cycles = 0;
    while (idx <= 10 && cycles < 300) begin
      rdy = 1'($urandom_range(0, 1));
      ready = rdy;
      step();
      cycles++;
      if (rdy) idx++;
      if (idx <= 10) expect_round("stall", idx, FIPS_RK[idx]);
      else           expect_done("stall", FIPS_RK[10]);
    end
    ready = 1'b1;
    step();

    // Start re-pulsed with another key at round 4 is ignored
    key_in = FIPS_KEY; start = 1'b1;
    step();
    start = 1'b0;
    expect_round("restart", 0, FIPS_KEY);
    for (int r = 1; r <= 10; r++) begin
      step();
      expect_round("restart", r, FIPS_RK[r]);
      if (r == 4) begin
        key_in = 128'h00112233445566778899aabbccddeeff;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    step();
    expect_done("restart", FIPS_RK[10]);

    // Reset at round 6 abandons the expansion, then a fresh run completes
    key_in = FIPS_KEY; start = 1'b1;
    step();
    start = 1'b0;
    expect_round("rstmid", 0, FIPS_KEY);
    for (int r = 1; r <= 6; r++) begin
      step();
      expect_round("rstmid", r, FIPS_RK[r]);
    end
    reset = 1'b1;
    step();
    expect_zero("rstmid_hit");
    reset = 1'b0;
    step();
    expect_zero("rstmid_after");
    start = 1'b1;
    step();
    start = 1'b0;
    expect_round("rerun", 0, FIPS_KEY);
    for (int r = 1; r <= 10; r++) begin
      step();
      expect_round("rerun", r, FIPS_RK[r]);
    end
    step();
    expect_done("rerun", FIPS_RK[10]);

    // Start held high across done: next expansion accepted in the done cycle
    key_in = FIPS_KEY; start = 1'b1;
    step();
    expect_round("hold", 0, FIPS_KEY);
    for (int r = 1; r <= 10; r++) begin
      step();
      expect_round("hold", r, FIPS_RK[r]);
      if (r == 3) key_in = '0;
    end
    step();
    expect_done("hold", FIPS_RK[10]);
    step();
    start = 1'b0;
    expect_round("hold2", 0, 128'(0));
    for (int r = 1; r <= 10; r++) begin
      step();
      chk($sformatf("hold2_r%0d_idx", r), 128'(round_idx), 128'(r));
      if (r == 1)  chk("hold2_r1_key", round_key, ZERO_R1);
      if (r == 10) chk("hold2_r10_key", round_key, ZERO_R10);
    end
    step();
    expect_done("hold2", ZERO_R10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
